// File: rtl/sd_pkg.sv
// Shared definitions for the SD command framer: frame geometry, the CRC7
// generator polynomial and the framer state encoding.
package sd_pkg;

    localparam int         SD_CMD_FRAME_BITS = 48;
    localparam int         SD_CMD_HDR_BITS   = 40;
    localparam logic [6:0] SD_CRC7_POLY      = 7'h09;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CRC,
        END,
        GAP
    } sd_cmd_state_t;

endpackage

// File: rtl/sd_crc7_lfsr.sv
// Serial CRC7 generator (x^7 + x^3 + 1), MSB-first, initial value zero.
// One message bit is folded in per enabled cycle; clr restarts the CRC.
module sd_crc7_lfsr
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic feedback;

    assign feedback = din ^ crc[6];

    // Shift the CRC left, folding the polynomial back in when the feedback bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? SD_CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_framer.sv
// SD command framer: accepts an index/argument pair, then serialises
// start, tx, index, argument, CRC7 and end bit on the CMD line, one bit per
// bit_en strobe, followed by an optional idle-high gap.
module sd_cmd_framer
    import sd_pkg::*;
#(
    parameter int GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        abort,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic [6:0]  crc_out,
    output logic        done
);

    localparam int GAP_W    = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam int CRC_BITS = SD_CMD_FRAME_BITS - SD_CMD_HDR_BITS - 1;

    sd_cmd_state_t state, state_nxt;

    logic [39:0]      shift_reg, shift_nxt;
    logic [5:0]       bit_cnt, bit_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             cmd_out_nxt, cmd_oe_nxt, done_nxt;
    logic             accept, step, crc_en;
    logic [2:0]       crc_idx;
    logic [6:0]       crc;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign step      = bit_en & ~abort;
    assign crc_en    = (state == DATA) & step;
    assign crc_idx   = 3'd5 - bit_cnt[2:0];
    assign crc_out   = crc;

    sd_crc7_lfsr u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (crc_en),
        .din   (cmd_out),
        .crc   (crc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: walk the frame fields on bit_en, abort returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = DATA;
            DATA: if (step && bit_cnt == 6'(SD_CMD_HDR_BITS - 1)) state_nxt = CRC;
            CRC:  if (step && bit_cnt == 6'(CRC_BITS - 1)) state_nxt = END;
            END:  if (step) state_nxt = (GAP_BITS == 0) ? IDLE : GAP;
            GAP:  if (step && gap_cnt == GAP_W'(GAP_BITS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    // Output/datapath next values: the bit shown next cycle and the counters.
    // Entering CRC the new CRC MSB is the old crc[5], since the final data bit
    // is being folded in on that same edge.
    always_comb begin
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        gap_nxt     = gap_cnt;
        cmd_out_nxt = cmd_out;
        cmd_oe_nxt  = cmd_oe;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_nxt   = {2'b01, cmd_index, cmd_arg};
                    bit_cnt_nxt = '0;
                    cmd_out_nxt = 1'b0;
                    cmd_oe_nxt  = 1'b1;
                end
            end
            DATA: begin
                if (step) begin
                    shift_nxt = shift_reg << 1;
                    if (bit_cnt == 6'(SD_CMD_HDR_BITS - 1)) begin
                        bit_cnt_nxt = '0;
                        cmd_out_nxt = crc[5];
                    end else begin
                        bit_cnt_nxt = bit_cnt + 6'd1;
                        cmd_out_nxt = shift_reg[38];
                    end
                end
            end
            CRC: begin
                if (step) begin
                    if (bit_cnt == 6'(CRC_BITS - 1)) begin
                        bit_cnt_nxt = '0;
                        cmd_out_nxt = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 6'd1;
                        cmd_out_nxt = crc[crc_idx];
                    end
                end
            end
            END: begin
                if (step) begin
                    cmd_out_nxt = 1'b1;
                    cmd_oe_nxt  = 1'b0;
                    done_nxt    = 1'b1;
                    gap_nxt     = '0;
                end
            end
            GAP: begin
                if (step) begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                cmd_out_nxt = 1'b1;
                cmd_oe_nxt  = 1'b0;
            end
        endcase
        if (abort && state != IDLE) begin
            cmd_out_nxt = 1'b1;
            cmd_oe_nxt  = 1'b0;
            done_nxt    = 1'b0;
            bit_cnt_nxt = '0;
        end
    end

    // Datapath registers; the line idles high with the driver disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            cmd_out   <= 1'b1;
            cmd_oe    <= 1'b0;
            done      <= 1'b0;
        end else begin
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            gap_cnt   <= gap_nxt;
            cmd_out   <= cmd_out_nxt;
            cmd_oe    <= cmd_oe_nxt;
            done      <= done_nxt;
        end
    end

endmodule
